// File: rtl/hyperbus_trans_arbiter.sv
// hyperbus_trans_arbiter: round-robin arbiter and burst sequencer sharing one HyperBus transaction datapath
module hyperbus_trans_arbiter #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*LenWidth-1:0]    req_len_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq-1:0]             req_is_16_bw_i,
    output logic                          trans_valid_o,
    input  logic                          trans_ready_i,
    output logic [AddrWidth-1:0]          trans_addr_o,
    output logic [LenWidth-1:0]           trans_len_o,
    output logic                          trans_write_o,
    output logic                          trans_is_16_bw_o,
    output logic                          trans_handshake_o,
    output logic                          start_addr_o,
    output logic                          first_tx_o,
    input  logic                          beat_valid_i,
    input  logic                          beat_ready_i,
    output logic                          beat_last_o,
    output logic [NumReq-1:0]             grant_o,
    output logic                          busy_o
);
    localparam int IdxW = NumReq > 1 ? $clog2(NumReq) : 1;
    typedef enum logic [1:0] {Idle, Issue, Data} state_e;
    state_e                state;
    logic [IdxW-1:0]       rr_ptr, owner, win_idx;
    logic                  win_valid, write_q, is16_q, first_q;
    logic [LenWidth-1:0]   cnt, len_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [NumReq-1:0]     grant_q;
    logic [2*NumReq-1:0]   rot;
    int                    off, sum;
    // Rotating the doubled request vector by rr_ptr makes bit 0 the highest-priority requester.
    always_comb begin
        rot = {req_valid_i, req_valid_i} >> rr_ptr;
        win_valid = 1'b0;
        off = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_valid = 1'b1;
                off = i;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NumReq) sum = sum - NumReq;
        win_idx = IdxW'(sum);
    end
    assign req_ready_o       = (rst_ni && state == Idle && win_valid) ? NumReq'(1) << win_idx : '0;
    assign busy_o            = state != Idle;
    assign trans_valid_o     = state == Issue;
    assign trans_handshake_o = trans_valid_o & trans_ready_i;
    assign trans_addr_o      = busy_o ? addr_q : '0;
    assign trans_len_o       = busy_o ? len_q : '0;
    assign trans_write_o     = busy_o & write_q;
    assign trans_is_16_bw_o  = busy_o & is16_q;
    assign start_addr_o      = busy_o & is16_q & addr_q[1];
    assign first_tx_o        = state == Data && first_q;
    assign beat_last_o       = state == Data && cnt == '0;
    assign grant_o           = grant_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= Idle;
            rr_ptr  <= '0;
            owner   <= '0;
            cnt     <= '0;
            first_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            write_q <= 1'b0;
            is16_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            case (state)
                Idle: if (win_valid) begin
                    state   <= Issue;
                    owner   <= win_idx;
                    addr_q  <= req_addr_i[win_idx*AddrWidth +: AddrWidth];
                    len_q   <= req_len_i[win_idx*LenWidth +: LenWidth];
                    write_q <= req_write_i[win_idx];
                    is16_q  <= req_is_16_bw_i[win_idx];
                    grant_q <= NumReq'(1) << win_idx;
                end
                Issue: if (trans_ready_i) begin
                    state   <= Data;
                    cnt     <= len_q;
                    first_q <= 1'b1;
                end
                Data: if (beat_valid_i && beat_ready_i) begin
                    first_q <= 1'b0;
                    if (cnt == '0) begin
                        state   <= Idle;
                        rr_ptr  <= (owner == IdxW'(NumReq - 1)) ? '0 : owner + 1'b1;
                        grant_q <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// tb_hyperbus_trans_arbiter: directed self-checking bench for hyperbus_trans_arbiter (NumReq=2 and NumReq=3 instances)
module tb_hyperbus_trans_arbiter;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [1:0]  req_valid = '0, req_write = '0, req_16 = '0;
    logic [1:0]  req_ready, grant;
    logic [63:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        trans_ready = 1'b0, beat_valid = 1'b0, beat_ready = 1'b0;
    logic        trans_valid, trans_write, trans_16, hs, start_addr, first_tx, beat_last, busy;
    logic [31:0] trans_addr;
    logic [7:0]  trans_len;

    logic [2:0]  v3 = '0, w3 = '0, b3 = '0;
    logic [2:0]  r3, g3;
    logic [95:0] a3 = '0;
    logic [23:0] l3 = '0;
    logic        tv3, tw3, tb3, hs3, sa3, ft3, bl3, busy3;
    logic [31:0] ta3;
    logic [7:0]  tl3;

    int n_checks = 0;
    int n_fail = 0;

    hyperbus_trans_arbiter u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_write_i(req_write), .req_is_16_bw_i(req_16),
        .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_addr_o(trans_addr),
        .trans_len_o(trans_len), .trans_write_o(trans_write), .trans_is_16_bw_o(trans_16),
        .trans_handshake_o(hs), .start_addr_o(start_addr), .first_tx_o(first_tx),
        .beat_valid_i(beat_valid), .beat_ready_i(beat_ready), .beat_last_o(beat_last),
        .grant_o(grant), .busy_o(busy)
    );

    hyperbus_trans_arbiter #(.NumReq(3)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(v3), .req_ready_o(r3), .req_addr_i(a3), .req_len_i(l3),
        .req_write_i(w3), .req_is_16_bw_i(b3),
        .trans_valid_o(tv3), .trans_ready_i(trans_ready), .trans_addr_o(ta3),
        .trans_len_o(tl3), .trans_write_o(tw3), .trans_is_16_bw_o(tb3),
        .trans_handshake_o(hs3), .start_addr_o(sa3), .first_tx_o(ft3),
        .beat_valid_i(beat_valid), .beat_ready_i(beat_ready), .beat_last_o(bl3),
        .grant_o(g3), .busy_o(busy3)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid = '0;
        v3 = '0;
        trans_ready = 1'b0;
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_valid = 2'b01;
        v3 = 3'b001;
        step();
        step();
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || r3 !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b want 00/000", req_ready, r3);
        end
        n_checks++;
        if ({trans_valid, hs, start_addr, first_tx, beat_last, busy, grant} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000000", {trans_valid, hs, start_addr, first_tx, beat_last, busy, grant});
        end
        n_checks++;
        if ({trans_addr, trans_len, trans_write, trans_16} !== 42'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h want 0", {trans_addr, trans_len, trans_write, trans_16});
        end
        req_valid = '0;
        v3 = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_addr[31:0] = 32'h1002;
        req_len[7:0] = 8'd3;
        req_16 = 2'b01;
        req_write = 2'b01;
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({trans_valid, grant, start_addr, hs, trans_write, trans_16} !== 7'b1011011) begin
            n_fail++;
            $display("FAIL single_issue: got %b want 1011011", {trans_valid, grant, start_addr, hs, trans_write, trans_16});
        end
        n_checks++;
        if (trans_addr !== 32'h1002 || trans_len !== 8'd3) begin
            n_fail++;
            $display("FAIL single_fields: got %h/%0d want 1002/3", trans_addr, trans_len);
        end
        trans_ready = 1'b1;
        #1;
        n_checks++;
        if (hs !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hs: got %b want 1", hs);
        end
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            n_checks++;
            if ({first_tx, beat_last, busy, hs, start_addr} !== {b == 0, b == 3, 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %b want %b", b, {first_tx, beat_last, busy, hs, start_addr}, {b == 0, b == 3, 1'b1, 1'b0, 1'b1});
            end
            step();
        end
        beat_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, grant, start_addr, trans_addr} !== 36'h0) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b grant=%b sa=%b addr=%h want all 0", busy, grant, start_addr, trans_addr);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        req_len = '0;
        req_16 = '0;
        req_valid = 2'b11;
        trans_ready = 1'b1;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            n_checks++;
            if (req_ready !== exp || busy !== 1'b0 || trans_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cont_ready%0d: got %b busy=%b tv=%b want %b busy=0 tv=0", k, req_ready, busy, trans_valid, exp);
            end
            step();
            #1;
            n_checks++;
            if (grant !== exp || trans_valid !== 1'b1 || hs !== 1'b1) begin
                n_fail++;
                $display("FAIL cont_issue%0d: got grant=%b tv=%b hs=%b want %b 1 1", k, grant, trans_valid, hs, exp);
            end
            step();
            #1;
            n_checks++;
            if (first_tx !== 1'b1 || beat_last !== 1'b1 || grant !== exp) begin
                n_fail++;
                $display("FAIL cont_beat%0d: got first=%b last=%b grant=%b want 1 1 %b", k, first_tx, beat_last, grant, exp);
            end
            step();
        end
        req_valid = '0;
        trans_ready = 1'b0;
        beat_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_addr[31:0] = 32'h1004;
        req_len[7:0] = 8'd1;
        req_16 = '0;
        req_write = '0;
        req_valid = 2'b01;
        step();
        req_valid = '0;
        req_addr[31:0] = 32'hDEAD_BEEF;
        req_len[7:0] = 8'd9;
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++;
            if (trans_valid !== 1'b1 || hs !== 1'b0 || trans_addr !== 32'h1004 || trans_len !== 8'd1) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got tv=%b hs=%b addr=%h len=%0d want 1 0 1004 1", s, trans_valid, hs, trans_addr, trans_len);
            end
            step();
        end
        trans_ready = 1'b1;
        #1;
        n_checks++;
        if (hs !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hs: got %b want 1", hs);
        end
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        #1;
        n_checks++;
        if ({first_tx, beat_last, busy, hs} !== 4'b1010) begin
            n_fail++;
            $display("FAIL bp_beat0: got %b want 1010", {first_tx, beat_last, busy, hs});
        end
        step();
        beat_ready = 1'b0;
        #1;
        n_checks++;
        if ({first_tx, beat_last, busy, hs} !== 4'b0110) begin
            n_fail++;
            $display("FAIL bp_stall_beat: got %b want 0110", {first_tx, beat_last, busy, hs});
        end
        step();
        beat_ready = 1'b1;
        #1;
        n_checks++;
        if ({first_tx, beat_last, busy, hs} !== 4'b0110) begin
            n_fail++;
            $display("FAIL bp_beat1: got %b want 0110", {first_tx, beat_last, busy, hs});
        end
        step();
        beat_ready = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || trans_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_exit: got busy=%b tv=%b want 0 0", busy, trans_valid);
        end
        beat_valid = 1'b0;
    endtask

    task automatic test_32bit();
        do_reset();
        req_addr[31:0] = 32'h2002;
        req_len[7:0] = 8'd0;
        req_16 = '0;
        req_valid = 2'b01;
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (start_addr !== 1'b0 || trans_16 !== 1'b0 || trans_valid !== 1'b1 || trans_addr !== 32'h2002) begin
            n_fail++;
            $display("FAIL w32_issue: got sa=%b bw16=%b tv=%b addr=%h want 0 0 1 2002", start_addr, trans_16, trans_valid, trans_addr);
        end
        trans_ready = 1'b1;
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        #1;
        n_checks++;
        if (start_addr !== 1'b0 || busy !== 1'b1 || beat_last !== 1'b1) begin
            n_fail++;
            $display("FAIL w32_data: got sa=%b busy=%b last=%b want 0 1 1", start_addr, busy, beat_last);
        end
        step();
        beat_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_addr = {32'h4000, 32'h3000};
        req_len = {8'd0, 8'd7};
        req_16 = '0;
        req_valid = 2'b01;
        step();
        req_valid = 2'b10;
        trans_ready = 1'b1;
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        step();
        step();
        #1;
        n_checks++;
        if ({busy, first_tx, beat_last, grant} !== 5'b10001) begin
            n_fail++;
            $display("FAIL mid_beat2: got %b want 10001", {busy, first_tx, beat_last, grant});
        end
        rst_ni = 1'b0;
        step();
        #1;
        n_checks++;
        if ({busy, trans_valid, first_tx, beat_last, hs, grant, req_ready} !== 9'h0 || trans_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b addr=%h want 0 addr=0", {busy, trans_valid, first_tx, beat_last, hs, grant, req_ready}, trans_addr);
        end
        rst_ni = 1'b1;
        beat_valid = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_rearb: got %b want 10", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if (grant !== 2'b10 || trans_addr !== 32'h4000 || trans_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grant1: got grant=%b addr=%h tv=%b want 10 4000 1", grant, trans_addr, trans_valid);
        end
        trans_ready = 1'b1;
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        step();
        beat_valid = 1'b0;
        beat_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        a3[95:64] = 32'h5000;
        l3 = '0;
        v3 = 3'b100;
        #1;
        n_checks++;
        if (r3 !== 3'b100) begin
            n_fail++;
            $display("FAIL wrap_ready2: got %b want 100", r3);
        end
        step();
        v3 = '0;
        trans_ready = 1'b1;
        #1;
        n_checks++;
        if (g3 !== 3'b100 || tv3 !== 1'b1 || ta3 !== 32'h5000) begin
            n_fail++;
            $display("FAIL wrap_grant2: got g=%b tv=%b addr=%h want 100 1 5000", g3, tv3, ta3);
        end
        step();
        trans_ready = 1'b0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        #1;
        n_checks++;
        if (ft3 !== 1'b1 || bl3 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_beat: got first=%b last=%b want 1 1", ft3, bl3);
        end
        step();
        beat_valid = 1'b0;
        v3 = 3'b101;
        #1;
        n_checks++;
        if (r3 !== 3'b001 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_ready0: got %b busy=%b want 001 0", r3, busy3);
        end
        step();
        v3 = '0;
        #1;
        n_checks++;
        if (g3 !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_grant0: got %b want 001", g3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_32bit();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
